// File: rtl/refill_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : refill_pkg
//  Brief    : Shared types, sizes and line-match helper for the refill arbiter
//  Revision : 1.0  initial release
// ============================================================================
package refill_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } refill_state_t;

   localparam int LineSize       = 128;
   localparam int ByteOffsetBits = 4;

   // Two addresses refer to the same refill line when their upper bits agree.
   function automatic logic line_match(input logic [31:0] a, input logic [31:0] b);
      return a[31:ByteOffsetBits] == b[31:ByteOffsetBits];
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Combinational two-way round-robin pick
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       grant_o,
   output logic       valid_o
);

   // A lone requester always wins; on a tie the port not served last wins.
   always_comb begin
      valid_o = |req_i;
      grant_o = 1'b0;
      if (&req_i) begin
         grant_o = ~last_grant_i;
      end else begin
         grant_o = req_i[1];
      end
   end

endmodule
`default_nettype wire

// File: rtl/refill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : refill_arbiter
//  Brief    : Shares one line-refill memory read port between two caches,
//             one outstanding transaction at a time, round-robin granted.
//  Revision : 1.0  initial release
// ============================================================================
module refill_arbiter #(
   parameter int LineSize       = 128,
   parameter int ByteOffsetBits = 4
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic [31:0]         m0_addr_i,
   input  logic                m0_read_en_i,
   output logic                m0_read_valid_o,
   output logic [LineSize-1:0] m0_read_data_o,
   input  logic [31:0]         m1_addr_i,
   input  logic                m1_read_en_i,
   output logic                m1_read_valid_o,
   output logic [LineSize-1:0] m1_read_data_o,
   output logic [31:0]         mem_addr_o,
   output logic                mem_read_en_o,
   input  logic                mem_read_valid_i,
   input  logic [LineSize-1:0] mem_read_data_i
);

   import refill_pkg::*;

   refill_state_t state_q, state_d;
   logic          grant_q, grant_d;
   logic          last_grant_q, last_grant_d;
   logic [31:0]   addr_q, addr_d;

   logic          arb_grant;
   logic          arb_valid;
   logic [31:0]   win_addr;
   logic          owner_ok;
   logic          resp_take;

   rr_arb2 u_rr_arb2 (
      .req_i        ({m1_read_en_i, m0_read_en_i}),
      .last_grant_i (last_grant_q),
      .grant_o      (arb_grant),
      .valid_o      (arb_valid)
   );

   assign win_addr = arb_grant ? m1_addr_i : m0_addr_i;

   // State and transaction latches; last_grant resets to 1 so port 0 wins the first tie.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         addr_q       <= 32'h0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
      end
   end

   // Next-state: grant from IDLE, return to IDLE on any response (taken or dropped).
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               state_d      = WAIT;
               grant_d      = arb_grant;
               last_grant_d = arb_grant;
               addr_d       = {win_addr[31:ByteOffsetBits], {ByteOffsetBits{1'b0}}};
            end
         end
         WAIT: begin
            if (mem_read_valid_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The owner must still want this exact line, otherwise the response is discarded.
   always_comb begin
      owner_ok = 1'b0;
      if (grant_q) begin
         owner_ok = m1_read_en_i && line_match(m1_addr_i, addr_q);
      end else begin
         owner_ok = m0_read_en_i && line_match(m0_addr_i, addr_q);
      end
   end

   assign resp_take       = (state_q == WAIT) && mem_read_valid_i && owner_ok;
   assign m0_read_valid_o = resp_take && !grant_q;
   assign m1_read_valid_o = resp_take &&  grant_q;

   assign m0_read_data_o  = mem_read_data_i;
   assign m1_read_data_o  = mem_read_data_i;

   assign mem_read_en_o   = (state_q == WAIT);
   assign mem_addr_o      = addr_q;

endmodule
`default_nettype wire

// File: doc/refill_arbiter.md
# refill_arbiter

Two-port arbiter that shares the single line-refill memory read port between two caches, typically the instruction cache (port 0) and the data cache (port 1). It accepts level-held miss requests and grants them round-robin. It latches the granted line address, drives one memory transaction at a time, and routes the returning line back to the requester that owns the transaction. It sits between the caches' `mem_*` ports and the memory model or bus.

## Interface
Parameters:
- `LineSize`, 128: refill line width in bits (4 × 32-bit words).
- `ByteOffsetBits`, 4: low address bits ignored for line matching.

Ports:
- `clk_i`  in  1: clock, all state on rising edge.
- `rstn_i`  in  1: reset, asynchronous, active-low.
- `m0_addr_i`  in  32: port 0 line address (the cache drives it line-aligned).
- `m0_read_en_i`  in  1: port 0 refill request, level, held until served.
- `m0_read_valid_o`  out  1: port 0 refill data valid, one-cycle pulse.
- `m0_read_data_o`  out  LineSize: port 0 refill line.
- `m1_addr_i`, `m1_read_en_i`, `m1_read_valid_o`, `m1_read_data_o`: same for port 1.
- `mem_addr_o`  out  32: latched address of the current transaction.
- `mem_read_en_o`  out  1: memory request, held high until `mem_read_valid_i`.
- `mem_read_valid_i`  in  1: memory response, one-cycle pulse.
- `mem_read_data_i`  in  LineSize: memory response line.

## Operation
- FSM states: IDLE, WAIT.
- **IDLE, no request:** stay in IDLE.
- **IDLE, any `mX_read_en_i` high:**
  - Pick the winner: with a single requester, that port wins; with both, the port ≠ `last_grant` wins.
  - Register `grant`, `last_grant`, and `addr_q` = winner address with bits [3:0] forced to 0.
  - Go to WAIT.
- **WAIT:** `mem_read_en_o`=1, `mem_addr_o`=`addr_q`.
- **WAIT with `mem_read_valid_i`=1:**
  - Pulse `m<grant>_read_valid_o` in the same cycle, combinationally, only if the owner is still valid: `m<grant>_read_en_i`=1 and `m<grant>_addr_i[31:4]`==`addr_q[31:4]`. Otherwise drop the response silently (owner aborted or changed line).
  - Go to IDLE.
- **Data path:** `m0_read_data_o` = `m1_read_data_o` = `mem_read_data_i` at all times. Only the valid pulses are steered.
- **Non-owner port:** its valid output is never asserted.
- `mem_read_valid_i` in IDLE is ignored (spurious).
- Requester changes while in WAIT do not change `mem_addr_o`.

## Timing
- **Reset values:**
  - State = IDLE, `grant`=0, `last_grant`=1 (port 0 wins the first tie), `addr_q`=0.
  - `mem_read_en_o`=0, `mem_addr_o`=0, both valid outputs 0.
  - Data outputs follow `mem_read_data_i`.
- **Outputs are registered:** `mem_read_en_o` and `mem_addr_o` are decoded from registered state only.
- **Grant latency:** a request first seen high in cycle N in IDLE gives `mem_read_en_o`=1 from cycle N+1.
- **Response latency:** valid pulse to the requester in the same cycle as `mem_read_valid_i`. Zero added latency.
- **Mandatory idle cycle:** after the response cycle the FSM spends at least one cycle in IDLE. The served cache has filled by then, so its stale `read_en` is not re-granted.
- **Back-to-back throughput:** one transaction per (memory latency + 2) cycles.
- **Fairness:** under continuous requests from both ports, grants strictly alternate 0,1,0,1.
- **Async reset mid-WAIT:** returns to IDLE immediately and drops `mem_read_en_o`. The memory side must tolerate an abandoned request. A late `mem_read_valid_i` arriving in IDLE is ignored.

## Structure
- A shared package `refill_pkg` holds:
  - `typedef enum logic {IDLE, WAIT} refill_state_t`
  - `LineSize`
  - `ByteOffsetBits`
  - `function line_match(a, b)` comparing bits [31:ByteOffsetBits]
- One sub-module, `rr_arb2`, is natural: a combinational 2-way round-robin pick from (req[1:0], last_grant), returning a grant index and a valid flag.
- The remainder (FSM, latches, response steering) stays in `refill_arbiter`.

## Test plan
- **Reset:** assert `rstn_i`=0 mid-WAIT with `mem_read_en_o`=1 → `mem_read_en_o`=0 asynchronously. After release, port 0 is granted first on a tie.
- **Single request:** `m0_read_en_i`=1, `m0_addr_i`=0x0000_1234, memory responds 5 cycles after `mem_read_en_o` rises with data 0xA5..A5 →
  - `mem_addr_o`=0x0000_1230.
  - `m0_read_valid_o` pulses 1 cycle with that data.
  - `m1_read_valid_o` stays 0.
- **Contention:** both ports request continuously, memory latency 3 → grants alternate 0,1,0,1. Each transaction spans 5 cycles, including the idle cycle.
- **Abort:** grant port 1, then drop `m1_read_en_i` before the response → no `m1_read_valid_o`. FSM returns to IDLE. Port 0's pending request is granted next.
- **Line change:** grant port 0 at 0x100, then switch `m0_addr_i` to 0x200 while in WAIT → response to 0x100 dropped. A new transaction starts at 0x200.
- **Spurious response:** `mem_read_valid_i`=1 in IDLE → no valid outputs, no state change.
